// File: rtl/lut_reverse_scan.sv
// Reverse lookup table: finds the key whose stored data matches a query.
// Default build scans one entry per cycle; define LUT_REV_PARALLEL_EN for a single-cycle compare.
module lut_reverse_scan #(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 8,
    localparam int IDX_W   = $clog2(NR_KEY)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                clr,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_LEN-1:0] req_data,
    input  logic [KEY_LEN-1:0]  default_key,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [KEY_LEN-1:0]  resp_key,
    output logic                resp_hit,
    output logic [IDX_W-1:0]    resp_idx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NR_KEY-1:0]     r_valid;
    logic [KEY_LEN-1:0]    r_key  [NR_KEY];
    logic [DATA_LEN-1:0]   r_data [NR_KEY];
    logic [DATA_LEN-1:0]   r_req_data;
    logic [KEY_LEN-1:0]    r_def_key;
    logic                  r_resp_valid;
    logic                  r_resp_hit;
    logic [KEY_LEN-1:0]    r_resp_key;
    logic [IDX_W-1:0]      r_resp_idx;
    logic                  w_accept;
    logic                  w_match;
    logic                  w_last;
    logic [IDX_W-1:0]      w_match_idx;

    assign req_ready  = (r_state == ST_IDLE) && rst_n;
    assign w_accept   = req_valid && req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_hit   = r_resp_hit;
    assign resp_key   = r_resp_key;
    assign resp_idx   = r_resp_idx;

`ifdef LUT_REV_PARALLEL_EN
    // Compare every entry at once; iterating downward lets the lowest index win.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        w_last      = 1'b1;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            w_match     = w_match | (r_valid[i] && (r_data[i] == r_req_data));
            w_match_idx = (r_valid[i] && (r_data[i] == r_req_data)) ? IDX_W'(i) : w_match_idx;
        end
    end
`else
    logic [IDX_W-1:0] r_idx;

    assign w_match     = r_valid[r_idx] && (r_data[r_idx] == r_req_data);
    assign w_match_idx = r_idx;
    assign w_last      = (r_idx == IDX_W'(NR_KEY - 1));

    // Scan pointer: restarts on accept, advances while nothing has matched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= '0;
        end else if ((r_state == ST_SCAN) && !w_match && !w_last) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end
`endif

    // Table storage; a same-cycle write lands after the clear, so it stays valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < NR_KEY; i++) begin
                r_key[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (clr) begin
                r_valid <= '0;
            end
            if (wr_en) begin
                r_valid[wr_idx] <= 1'b1;
                r_key[wr_idx]   <= wr_key;
                r_data[wr_idx]  <= wr_data;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SCAN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (w_match || w_last) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request capture and response registers; results hold until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_data   <= '0;
            r_def_key    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_key   <= '0;
            r_resp_idx   <= '0;
        end else begin
            if (w_accept) begin
                r_req_data <= req_data;
                r_def_key  <= default_key;
            end
            if (r_state == ST_SCAN) begin
                if (w_match) begin
                    r_resp_valid <= 1'b1;
                    r_resp_hit   <= 1'b1;
                    r_resp_key   <= r_key[w_match_idx];
                    r_resp_idx   <= w_match_idx;
                end else if (w_last) begin
                    r_resp_valid <= 1'b1;
                    r_resp_hit   <= 1'b0;
                    r_resp_key   <= r_def_key;
                    r_resp_idx   <= '0;
                end
            end else if ((r_state == ST_RESP) && resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

endmodule
